// File: rtl/e_slot_alloc.sv
// Round-robin slot allocator around the circular left-most-'0' finder `e`.
// Optional free-protocol checking is built when E_SLOT_ALLOC_CHECK_EN is defined.

module e #(
   parameter int W = 32
) (
   input  logic [W-1:0]         x_i,
   input  logic [$clog2(W)-1:0] pos_i,
   output logic                 any_o,
   output logic [$clog2(W)-1:0] y_enc_o
);
   localparam int IW = $clog2(W);

   logic [IW-1:0] idx;

   // Walk from the far end of the search order back to pos-1 so the last
   // hit written is the first zero in the order pos-1, pos-2, ..., pos.
   always_comb begin
      any_o   = 1'b0;
      y_enc_o = '0;
      idx     = '0;
      for (int k = W; k >= 1; k--) begin
         idx = pos_i - IW'(k);
         if (!x_i[idx]) begin
            any_o   = 1'b1;
            y_enc_o = idx;
         end
      end
   end
endmodule

module e_slot_alloc #(
   parameter int W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_rdy_i,
   output logic                 alloc_vld_o,
   output logic [$clog2(W)-1:0] alloc_id_o,
   input  logic                 free_vld_i,
   input  logic [$clog2(W)-1:0] free_id_i,
   output logic [W-1:0]         busy_o,
   output logic                 full_o,
   output logic                 err_o
);
   localparam int IW = $clog2(W);

   logic [W-1:0]  busy_q,    busy_d;
   logic [IW-1:0] pos_q,     pos_d;
   logic          stg_vld_q, stg_vld_d;
   logic [IW-1:0] stg_id_q,  stg_id_d;
   logic          ld;
   logic          any;
   logic [IW-1:0] y_enc;

   e #(.W(W)) u_e (
      .x_i     (busy_q),
      .pos_i   (pos_q),
      .any_o   (any),
      .y_enc_o (y_enc)
   );

   // Handshake: the staged slot transfers on alloc_vld_o & alloc_rdy_i; the
   // stage reloads whenever it is empty or being taken this cycle.
   assign ld = !stg_vld_q | alloc_rdy_i;

   always_comb begin
      busy_d    = busy_q;
      pos_d     = pos_q;
      stg_vld_d = stg_vld_q;
      stg_id_d  = stg_id_q;
      if (free_vld_i) begin
         busy_d[free_id_i] = 1'b0;
      end
      // Applied after the clear so a same-index set wins.
      if (ld) begin
         if (any) begin
            stg_vld_d      = 1'b1;
            stg_id_d       = y_enc;
            busy_d[y_enc]  = 1'b1;
            pos_d          = y_enc;
         end else begin
            stg_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= '0;
         pos_q     <= '0;
         stg_vld_q <= 1'b0;
         stg_id_q  <= '0;
      end else begin
         busy_q    <= busy_d;
         pos_q     <= pos_d;
         stg_vld_q <= stg_vld_d;
         stg_id_q  <= stg_id_d;
      end
   end

`ifdef E_SLOT_ALLOC_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (free_vld_i && (!busy_q[free_id_i] || (stg_vld_q && (free_id_i == stg_id_q)))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign alloc_vld_o = stg_vld_q;
   assign alloc_id_o  = stg_id_q;
   assign busy_o      = busy_q;
   assign full_o      = &busy_q;
endmodule
